// File: rtl/regread_arbiter.sv
// Two-port read arbiter for the 64x32 register file: port 0 (pipeline) has priority,
// and port 1 (debug) is guaranteed a grant after STARVE_LIMIT consecutive losses.
module regread_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter bit ZR_EN        = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    output logic        req1_ready,
    output logic [4:0]  regsel,
    input  logic [63:0] rd,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [63:0] rsp_data
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    logic        r_a_valid;
    logic        r_a_id;
    logic        r_a_zr;
    logic [4:0]  r_regsel;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [63:0] r_rsp_data;

    logic        w_starved;
    logic        w_handshake;
    logic [4:0]  w_addr;

    // Readies are gated by reset so nothing is granted while the pipeline is held in reset.
    assign w_starved   = (r_starve_cnt == LIMIT);
    assign req1_ready  = reset_n & ~stall & req1_valid & (w_starved | ~req0_valid);
    assign req0_ready  = reset_n & ~stall & req0_valid & ~(req1_valid & w_starved);
    assign w_handshake = req0_ready | req1_ready;
    assign w_addr      = req1_ready ? req1_addr : req0_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!stall) begin
            if (!req1_valid || req1_ready)
                r_starve_cnt <= 4'd0;
            else if (!w_starved)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Stage A: latch the select for the read mux plus the tag that travels with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regsel  <= 5'd0;
            r_a_valid <= 1'b0;
            r_a_id    <= 1'b0;
            r_a_zr    <= 1'b0;
        end else begin
            r_a_valid <= w_handshake;
            if (w_handshake) begin
                r_regsel <= w_addr;
                r_a_id   <= req1_ready;
                r_a_zr   <= ZR_EN && (w_addr == 5'd31);
            end
        end
    end

    // Stage B: capture mux data; the response registers hold between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 64'd0;
        end else begin
            r_rsp_valid <= r_a_valid;
            if (r_a_valid) begin
                r_rsp_id   <= r_a_id;
                r_rsp_data <= r_a_zr ? 64'd0 : rd;
            end
        end
    end

    assign regsel    = r_regsel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_regread_arbiter.sv
// Directed and randomized checks of regread_arbiter against a cycle model of the
// grant, starvation and two-stage response behaviour.
module tb_regread_arbiter;
    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic        req1_ready;
    logic [4:0]  regsel;
    logic [63:0] rd;
    logic        rsp_valid;
    logic        rsp_id;
    logic [63:0] rsp_data;

    logic        nz_req0_ready;
    logic        nz_req1_ready;
    logic [4:0]  nz_regsel;
    logic [63:0] nz_rd;
    logic        nz_rsp_valid;
    logic        nz_rsp_id;
    logic [63:0] nz_rsp_data;

    logic [63:0] regs [32];

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0]  m_cnt;
    logic        m_a_v;
    logic        m_a_id;
    logic        m_a_zr;
    logic [4:0]  m_a_addr;
    logic [4:0]  m_sel;
    logic        m_rv;
    logic        m_rid;
    logic [63:0] m_rdata;

    assign rd    = regs[regsel];
    assign nz_rd = regs[nz_regsel];

    regread_arbiter #(.STARVE_LIMIT(4), .ZR_EN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .regsel(regsel), .rd(rd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    regread_arbiter #(.STARVE_LIMIT(4), .ZR_EN(1'b0)) u_dut_nz (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(nz_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(nz_req1_ready),
        .regsel(nz_regsel), .rd(nz_rd),
        .rsp_valid(nz_rsp_valid), .rsp_id(nz_rsp_id), .rsp_data(nz_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_val(input int i);
        return {16'hC0DE, 16'(i), 32'h5A5A_0000 + 32'(i)};
    endfunction

    task automatic drive(input logic v0, input logic [4:0] a0, input logic v1,
                         input logic [4:0] a1, input logic st);
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1;
        stall      = st;
    endtask

    task automatic m_reset();
        m_cnt = 4'd0; m_a_v = 1'b0; m_a_id = 1'b0; m_a_zr = 1'b0; m_a_addr = 5'd0;
        m_sel = 5'd0; m_rv = 1'b0; m_rid = 1'b0; m_rdata = 64'd0;
    endtask

    // One clock cycle: check readies against the model, advance model and DUT, check outputs.
    task automatic tick();
        logic e0, e1;
        e1 = !stall && req1_valid && (m_cnt == 4'd4 || !req0_valid);
        e0 = !stall && req0_valid && !e1;
        #1;
        chk("req0_ready", 64'(req0_ready), 64'(e0));
        chk("req1_ready", 64'(req1_ready), 64'(e1));
        chk("ready_excl", 64'(req0_ready & req1_ready), 64'd0);
        m_rv = m_a_v;
        if (m_a_v) begin
            m_rid   = m_a_id;
            m_rdata = m_a_zr ? 64'd0 : regs[m_a_addr];
        end
        if (e0 || e1) begin
            m_a_id   = e1;
            m_a_addr = e1 ? req1_addr : req0_addr;
            m_a_zr   = (m_a_addr == 5'd31);
            m_sel    = m_a_addr;
        end
        m_a_v = e0 || e1;
        if (!stall) begin
            if (!req1_valid || e1) m_cnt = 4'd0;
            else if (m_cnt != 4'd4) m_cnt = m_cnt + 4'd1;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        chk("rsp_id", 64'(rsp_id), 64'(m_rid));
        chk("rsp_data", rsp_data, m_rdata);
        chk("regsel", 64'(regsel), 64'(m_sel));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = exp_val(i);
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        m_reset();
        #1;
        chk("rst_regsel", 64'(regsel), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Single read of register 5.
        regs[5] = 64'hDEAD_BEEF_0123_4567;
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        tick();
        chk("single_n1_valid", 64'(rsp_valid), 64'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("single_valid", 64'(rsp_valid), 64'd1);
        chk("single_id", 64'(rsp_id), 64'd0);
        chk("single_data", rsp_data, 64'hDEAD_BEEF_0123_4567);
        $display("single read: id=%0d data=%h", rsp_id, rsp_data);
        regs[5] = exp_val(5);

        // Back-to-back reads of every register, including the zero register.
        for (int i = 0; i < 33; i++) begin
            if (i < 32) drive(1'b1, 5'(i), 1'b0, 5'd0, 1'b0);
            else        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
            if (i >= 1) begin
                chk("b2b_valid", 64'(rsp_valid), 64'd1);
                chk("b2b_data", rsp_data, (i - 1 == 31) ? 64'd0 : exp_val(i - 1));
                if (i - 1 == 31) chk("b2b_nozr_data", nz_rsp_data, exp_val(31));
            end
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("b2b_end_valid", 64'(rsp_valid), 64'd0);

        // Starvation: both ports held valid, port 1 wins every fifth cycle.
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0);
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("starve_rdy1", 64'(req1_ready), 64'(k % 5 == 4));
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();

        // Stall: in-flight request completes, new one granted when stall drops.
        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_rdy0", 64'(req0_ready), 64'd0);
            tick();
            if (k == 0) begin
                chk("stall_inflight_valid", 64'(rsp_valid), 64'd1);
                chk("stall_inflight_data", rsp_data, exp_val(7));
                $display("stall in-flight: id=%0d data=%h", rsp_id, rsp_data);
            end
        end
        stall = 1'b0;
        #1;
        chk("unstall_rdy0", 64'(req0_ready), 64'd1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("unstall_data", rsp_data, exp_val(8));
        $display("post-stall: id=%0d data=%h", rsp_id, rsp_data);

        // Reset mid-flight discards the accepted request.
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_regsel", 64'(regsel), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_data", rsp_data, 64'd0);
        chk("midrst_rdy0", 64'(req0_ready), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("postrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
        #1;
        chk("postrst_grant", 64'(req0_ready), 64'd1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("postrst_data", rsp_data, exp_val(3));

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 99) < 80, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < 15);
            if ($urandom_range(0, 3) == 0)
                regs[$urandom_range(0, 31)] = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
